// File: rtl/player_frame_rx.sv
// Receive side of the inter-FPGA player-state link: 8N1 UART deserialiser feeding a
// 6-byte frame parser that updates per-player registers on checksum-verified frames.
module player_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_CLKS = 20000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] player_ID,
  output logic [1:0] p1_direction,
  output logic [8:0] p1_loc_x,
  output logic [8:0] p1_loc_y,
  output logic [3:0] p1_state,
  output logic [1:0] p2_direction,
  output logic [8:0] p2_loc_x,
  output logic [8:0] p2_loc_y,
  output logic [3:0] p2_state,
  output logic [1:0] p3_direction,
  output logic [8:0] p3_loc_x,
  output logic [8:0] p3_loc_y,
  output logic [3:0] p3_state,
  output logic [1:0] p4_direction,
  output logic [8:0] p4_loc_x,
  output logic [8:0] p4_loc_y,
  output logic [3:0] p4_state,
  output logic       frame_valid,
  output logic [1:0] frame_id,
  output logic [7:0] err_count
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] B_IDLE  = 3'd0;
  localparam logic [2:0] B_START = 3'd1;
  localparam logic [2:0] B_DATA  = 3'd2;
  localparam logic [2:0] B_STOP  = 3'd3;
  localparam logic [2:0] B_BREAK = 3'd4;

  localparam logic [2:0] F_HUNT = 3'd0;
  localparam logic [2:0] F_HDR  = 3'd1;
  localparam logic [2:0] F_XLO  = 3'd2;
  localparam logic [2:0] F_YLO  = 3'd3;
  localparam logic [2:0] F_EXT  = 3'd4;
  localparam logic [2:0] F_CSUM = 3'd5;

  logic          rx_meta_q, rxs_q;
  logic [2:0]    bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    fst_q, fst_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]    sh_hdr_q, sh_hdr_d;
  logic [7:0]    sh_x_q, sh_x_d;
  logic [7:0]    sh_y_q, sh_y_d;
  logic [3:0]    sh_ext_q, sh_ext_d;
  logic [7:0]    csum_q, csum_d;
  logic [1:0]    dir_q [4];
  logic [1:0]    dir_d [4];
  logic [8:0]    x_q [4];
  logic [8:0]    x_d [4];
  logic [8:0]    y_q [4];
  logic [8:0]    y_d [4];
  logic [3:0]    st_q [4];
  logic [3:0]    st_d [4];
  logic          frame_valid_q, frame_valid_d;
  logic [1:0]    frame_id_q, frame_id_d;
  logic [7:0]    err_q, err_d;

  logic byte_stb, framing_err, frame_err, timeout;

  always_comb begin
    bst_d         = bst_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    fst_d         = fst_q;
    to_cnt_d      = to_cnt_q;
    sh_hdr_d      = sh_hdr_q;
    sh_x_d        = sh_x_q;
    sh_y_d        = sh_y_q;
    sh_ext_d      = sh_ext_q;
    csum_d        = csum_q;
    dir_d         = dir_q;
    x_d           = x_q;
    y_d           = y_q;
    st_d          = st_q;
    frame_valid_d = 1'b0;
    frame_id_d    = frame_id_q;
    err_d         = err_q;
    byte_stb      = 1'b0;
    framing_err   = 1'b0;
    frame_err     = 1'b0;
    timeout       = 1'b0;

    // Bit-level receiver: half-bit alignment on the start bit, then sample at bit centres
    case (bst_q)
      B_IDLE: begin
        if (!rxs_q) begin
          bst_d = B_START;
          cnt_d = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          bst_d     = rxs_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bst_d = B_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_stb = 1'b1;
            bst_d    = B_IDLE;
          end else begin
            framing_err = 1'b1;
            bst_d       = B_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_BREAK: begin
        if (rxs_q) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase

    // Inter-byte watchdog, armed only while a frame is in progress
    if (fst_q == F_HUNT || byte_stb) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_M1) begin
      timeout  = 1'b1;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (framing_err || timeout) begin
      fst_d = F_HUNT;
    end else if (byte_stb) begin
      case (fst_q)
        F_HUNT: if (shift_q == SYNC_BYTE) fst_d = F_HDR;
        F_HDR: begin
          if (shift_q[7:6] != 2'b00) begin
            frame_err = 1'b1;
            fst_d     = F_HUNT;
          end else begin
            sh_hdr_d = shift_q[5:0];
            csum_d   = shift_q;
            fst_d    = F_XLO;
          end
        end
        F_XLO: begin
          sh_x_d = shift_q;
          csum_d = csum_q ^ shift_q;
          fst_d  = F_YLO;
        end
        F_YLO: begin
          sh_y_d = shift_q;
          csum_d = csum_q ^ shift_q;
          fst_d  = F_EXT;
        end
        F_EXT: begin
          sh_ext_d = {shift_q[7:6], shift_q[1:0]};
          csum_d   = csum_q ^ shift_q;
          fst_d    = F_CSUM;
        end
        F_CSUM: begin
          fst_d = F_HUNT;
          if (shift_q != csum_q) begin
            frame_err = 1'b1;
          end else if (sh_hdr_q[5:4] != player_ID) begin
            dir_d[sh_hdr_q[5:4]] = sh_ext_q[3:2];
            x_d[sh_hdr_q[5:4]]   = {sh_ext_q[0], sh_x_q};
            y_d[sh_hdr_q[5:4]]   = {sh_ext_q[1], sh_y_q};
            st_d[sh_hdr_q[5:4]]  = sh_hdr_q[3:0];
            frame_valid_d        = 1'b1;
            frame_id_d           = sh_hdr_q[5:4];
          end
        end
        default: fst_d = F_HUNT;
      endcase
    end

    // Coincident error sources collapse into a single increment
    if ((frame_err || framing_err || timeout) && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      bst_q         <= B_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      fst_q         <= F_HUNT;
      to_cnt_q      <= '0;
      sh_hdr_q      <= 6'd0;
      sh_x_q        <= 8'd0;
      sh_y_q        <= 8'd0;
      sh_ext_q      <= 4'd0;
      csum_q        <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        dir_q[i] <= 2'd0;
        x_q[i]   <= 9'd0;
        y_q[i]   <= 9'd0;
        st_q[i]  <= 4'd0;
      end
      frame_valid_q <= 1'b0;
      frame_id_q    <= 2'd0;
      err_q         <= 8'd0;
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      bst_q         <= bst_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      fst_q         <= fst_d;
      to_cnt_q      <= to_cnt_d;
      sh_hdr_q      <= sh_hdr_d;
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      sh_ext_q      <= sh_ext_d;
      csum_q        <= csum_d;
      dir_q         <= dir_d;
      x_q           <= x_d;
      y_q           <= y_d;
      st_q          <= st_d;
      frame_valid_q <= frame_valid_d;
      frame_id_q    <= frame_id_d;
      err_q         <= err_d;
    end
  end

  assign p1_direction = dir_q[0];
  assign p1_loc_x     = x_q[0];
  assign p1_loc_y     = y_q[0];
  assign p1_state     = st_q[0];
  assign p2_direction = dir_q[1];
  assign p2_loc_x     = x_q[1];
  assign p2_loc_y     = y_q[1];
  assign p2_state     = st_q[1];
  assign p3_direction = dir_q[2];
  assign p3_loc_x     = x_q[2];
  assign p3_loc_y     = y_q[2];
  assign p3_state     = st_q[2];
  assign p4_direction = dir_q[3];
  assign p4_loc_x     = x_q[3];
  assign p4_loc_y     = y_q[3];
  assign p4_state     = st_q[3];
  assign frame_valid  = frame_valid_q;
  assign frame_id     = frame_id_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_player_frame_rx.sv
// Bench for player_frame_rx: serial stimulus at 16 clks/bit, frame-level reference model.
module tb_player_frame_rx;
  localparam int unsigned CPB = 16;
  localparam int unsigned TO  = 1000;

  typedef struct packed {
    logic [47:0] bytes;
    logic [1:0]  pid;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rx;
  logic [1:0] pid;
  logic [1:0] p1_direction, p2_direction, p3_direction, p4_direction;
  logic [8:0] p1_loc_x, p2_loc_x, p3_loc_x, p4_loc_x;
  logic [8:0] p1_loc_y, p2_loc_y, p3_loc_y, p4_loc_y;
  logic [3:0] p1_state, p2_state, p3_state, p4_state;
  logic       frame_valid;
  logic [1:0] frame_id;
  logic [7:0] err_count;

  player_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx(rx), .player_ID(pid),
    .p1_direction(p1_direction), .p1_loc_x(p1_loc_x), .p1_loc_y(p1_loc_y), .p1_state(p1_state),
    .p2_direction(p2_direction), .p2_loc_x(p2_loc_x), .p2_loc_y(p2_loc_y), .p2_state(p2_state),
    .p3_direction(p3_direction), .p3_loc_x(p3_loc_x), .p3_loc_y(p3_loc_y), .p3_state(p3_state),
    .p4_direction(p4_direction), .p4_loc_x(p4_loc_x), .p4_loc_y(p4_loc_y), .p4_state(p4_state),
    .frame_valid(frame_valid), .frame_id(frame_id), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [1:0] a_dir [4];
  logic [8:0] a_x [4];
  logic [8:0] a_y [4];
  logic [3:0] a_st [4];
  always_comb begin
    a_dir[0] = p1_direction; a_x[0] = p1_loc_x; a_y[0] = p1_loc_y; a_st[0] = p1_state;
    a_dir[1] = p2_direction; a_x[1] = p2_loc_x; a_y[1] = p2_loc_y; a_st[1] = p2_state;
    a_dir[2] = p3_direction; a_x[2] = p3_loc_x; a_y[2] = p3_loc_y; a_st[2] = p3_state;
    a_dir[3] = p4_direction; a_x[3] = p4_loc_x; a_y[3] = p4_loc_y; a_st[3] = p4_state;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int fv_count = 0;

  always @(negedge clk) if (frame_valid) fv_count++;

  // Reference model state
  int         m_err;
  int         m_fv;
  logic [1:0] m_fid;
  logic [1:0] m_dir [4];
  logic [8:0] m_x [4];
  logic [8:0] m_y [4];
  logic [3:0] m_st [4];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0;
    m_fid = 2'd0;
    for (int i = 0; i < 4; i++) begin
      m_dir[i] = 2'd0; m_x[i] = 9'd0; m_y[i] = 9'd0; m_st[i] = 4'd0;
    end
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_frame(input logic [47:0] f, input logic [1:0] p);
    logic [7:0] b1, b2, b3, b4, b5;
    int id;
    b1 = f[39:32]; b2 = f[31:24]; b3 = f[23:16]; b4 = f[15:8]; b5 = f[7:0];
    id = int'(b1[5:4]);
    if (b1[7:6] != 2'b00 || (b1 ^ b2 ^ b3 ^ b4) != b5) begin
      model_err();
    end else if (b1[5:4] != p) begin
      m_st[id]  = b1[3:0];
      m_x[id]   = 9'(int'(b4[0]) * 256 + int'(b2));
      m_y[id]   = 9'(int'(b4[1]) * 256 + int'(b3));
      m_dir[id] = b4[7:6];
      m_fid     = b1[5:4];
      m_fv++;
    end
  endtask

  function automatic logic [47:0] make_frame(input logic [1:0] id, input logic [3:0] st,
                                             input logic [8:0] x, input logic [8:0] y,
                                             input logic [1:0] dir);
    logic [7:0] b1, b2, b3, b4;
    b1 = {2'b00, id, st};
    b2 = x[7:0];
    b3 = y[7:0];
    b4 = {dir, 4'b0000, y[8], x[8]};
    return {8'hA5, b1, b2, b3, b4, b1 ^ b2 ^ b3 ^ b4};
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s frame_valid_pulses", tag), fv_count, m_fv);
    chk($sformatf("%s frame_id", tag), int'(frame_id), int'(m_fid));
    chk($sformatf("%s err_count", tag), int'(err_count), m_err);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s p%0d_direction", tag, i + 1), int'(a_dir[i]), int'(m_dir[i]));
      chk($sformatf("%s p%0d_loc_x", tag, i + 1), int'(a_x[i]), int'(m_x[i]));
      chk($sformatf("%s p%0d_loc_y", tag, i + 1), int'(a_y[i]), int'(m_y[i]));
      chk($sformatf("%s p%0d_state", tag, i + 1), int'(a_st[i]), int'(m_st[i]));
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int k = 0; k < 6; k++) send_byte(f[47 - 8 * k -: 8], 1'b1);
    idle(24);
  endtask

  vec_t vecs [7];

  initial begin
    logic [47:0] f;
    logic [7:0]  junk;
    logic [7:0]  flip;
    logic [1:0]  id;
    int          err0, fv0, kind;

    vecs[0] = '{48'hA5_12_34_56_C3_B3, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{48'hA5_12_34_56_C3_B2, 2'd0, 1'b0, 1'b1};
    vecs[2] = '{48'hA5_02_34_56_C3_A3, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{48'hA5_02_34_56_C3_A3, 2'd3, 1'b1, 1'b0};
    vecs[4] = '{48'hA5_52_34_56_C3_F3, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{48'hA5_33_A5_A5_40_73, 2'd0, 1'b1, 1'b0};
    vecs[6] = '{48'hA5_3F_FF_FF_FF_C0, 2'd1, 1'b1, 1'b0};

    rst = 1'b1; rx = 1'b1; pid = 2'd0; m_fv = 0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(10);
    check_all("reset");

    // Directed frame table
    for (int v = 0; v < 7; v++) begin
      pid  = vecs[v].pid;
      err0 = m_err;
      fv0  = fv_count;
      send_frame(vecs[v].bytes);
      chk($sformatf("vec%0d valid", v), fv_count - fv0, int'(vecs[v].exp_valid));
      chk($sformatf("vec%0d err", v), int'(err_count), err0 + int'(vecs[v].exp_err));
      model_frame(vecs[v].bytes, vecs[v].pid);
      check_all($sformatf("vec%0d", v));
    end
    pid = 2'd0;
    chk("spec p2_loc_x", int'(p2_loc_x), 'h134);
    chk("spec p2_loc_y", int'(p2_loc_y), 'h156);

    // Short low glitch must not produce a byte or an error
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check_all("glitch");
    f = make_frame(2'd2, 4'd9, 9'd300, 9'd17, 2'd1);
    send_frame(f);
    model_frame(f, pid);
    check_all("after_glitch");

    // Stop bit low on b3 aborts the frame with one error
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    idle(24);
    model_err();
    check_all("framing_b3");
    f = make_frame(2'd3, 4'd5, 9'd511, 9'd256, 2'd2);
    send_frame(f);
    model_frame(f, pid);
    check_all("after_framing");

    // Stall past the inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    idle(TO + 10);
    model_err();
    check_all("timeout");

    // Stall just under the timeout: frame still accepted
    f = make_frame(2'd1, 4'd7, 9'd77, 9'd400, 2'd0);
    send_byte(f[47:40], 1'b1);
    send_byte(f[39:32], 1'b1);
    idle(700);
    for (int k = 2; k < 6; k++) send_byte(f[47 - 8 * k -: 8], 1'b1);
    idle(24);
    model_frame(f, pid);
    check_all("near_timeout");

    // Randomised frames against the model
    for (int r = 0; r < 10; r++) begin
      pid  = 2'($urandom_range(0, 3));
      id   = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      if (kind == 2) id = pid;
      f = make_frame(id, 4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)),
                     9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
      if (kind == 1) begin
        flip = 8'h01 << $urandom_range(0, 7);
        f[7:0] = f[7:0] ^ flip;
      end
      if (kind == 3) begin
        f[39:38] = 2'($urandom_range(1, 3));
        for (int k = 0; k < 4; k++) if (f[k * 8 +: 8] == 8'hA5) f[k * 8] = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, 1'b1);
      end
      send_frame(f);
      model_frame(f, pid);
      check_all($sformatf("rand%0d", r));
    end
    pid = 2'd0;

    // Error counter saturation via repeated framing errors
    while (m_err < 255) begin
      send_byte(8'h00, 1'b0);
      model_err();
    end
    idle(8);
    check_all("sat_255");
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h00, 1'b0);
      model_err();
    end
    idle(8);
    check_all("sat_hold");

    // Reset in the middle of a byte inside a frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    fork
      send_byte(8'h34, 1'b1);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(10);
    model_reset();
    check_all("mid_reset");
    f = make_frame(2'd1, 4'd2, 9'h134, 9'h156, 2'd3);
    send_frame(f);
    model_frame(f, pid);
    check_all("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
